// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit for the fetch side.
// Arbitrates EX redirects, ID load-use stalls, EX multicycle stalls and
// data-memory wait into registered jump / hold / flush controls.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   jump_req_i        redirect request pulse from EX
//   jump_addr_i       redirect target, valid with jump_req_i
//   load_use_i        load-use hazard from ID (one stall cycle)
//   mc_start_i        multicycle op start pulse from EX
//   mc_cycles_i       stall length for mc_start_i (0 = no stall)
//   mem_wait_i        data memory busy (level)
//   jump_en           load jump_addr into the PC this cycle
//   jump_addr         redirect target
//   hold_en           freeze PC and IF/ID
//   flush_en          replace IF/ID contents with a bubble
//   busy_o            controller not idle
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MC_W         = 6,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_req_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              load_use_i,
  input  logic              mc_start_i,
  input  logic [MC_W-1:0]   mc_cycles_i,
  input  logic              mem_wait_i,
  output logic              jump_en,
  output logic [ADDR_W-1:0] jump_addr,
  output logic              hold_en,
  output logic              flush_en,
  output logic              busy_o
);

  // One counter serves both the stall length and the flush length.
  localparam int unsigned CNT_W = (MC_W > 4) ? MC_W : 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MC_STALL = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              hold_r;
  logic              pend;
  logic [ADDR_W-1:0] pend_addr;

  logic              issue;
  logic [ADDR_W-1:0] issue_addr;

  // A jump issues immediately from IDLE/FLUSH; from MC_STALL it waits for
  // the last stall cycle, where a request arriving that very cycle wins
  // over the older pending address.
  always_comb begin
    issue      = 1'b0;
    issue_addr = jump_addr_i;
    case (state)
      IDLE, FLUSH: issue = jump_req_i;
      MC_STALL: begin
        issue      = (cnt == CNT_W'(1)) && (pend || jump_req_i);
        issue_addr = jump_req_i ? jump_addr_i : pend_addr;
      end
      default: issue = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hold_r    <= 1'b0;
      pend      <= 1'b0;
      pend_addr <= '0;
      jump_en   <= 1'b0;
      jump_addr <= '0;
      flush_en  <= 1'b0;
    end else begin
      jump_en <= 1'b0;
      hold_r  <= 1'b0;
      if (issue) begin
        state     <= FLUSH;
        cnt       <= CNT_W'(FLUSH_CYCLES);
        jump_en   <= 1'b1;
        jump_addr <= issue_addr;
        flush_en  <= 1'b1;
        pend      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (mc_start_i && (mc_cycles_i != '0)) begin
              state  <= MC_STALL;
              cnt    <= CNT_W'(mc_cycles_i);
              hold_r <= 1'b1;
            end else if (load_use_i) begin
              hold_r <= 1'b1;
            end
          end
          MC_STALL: begin
            if (jump_req_i) begin
              pend      <= 1'b1;
              pend_addr <= jump_addr_i;
            end
            if (cnt == CNT_W'(1)) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              cnt    <= cnt - CNT_W'(1);
              hold_r <= 1'b1;
            end
          end
          FLUSH: begin
            // Bubbles are only consumed while memory lets the pipe advance.
            if (!mem_wait_i) begin
              if (cnt == CNT_W'(1)) begin
                state    <= IDLE;
                cnt      <= '0;
                flush_en <= 1'b0;
              end else begin
                cnt <= cnt - CNT_W'(1);
              end
            end
          end
          default: begin
            state    <= IDLE;
            cnt      <= '0;
            flush_en <= 1'b0;
          end
        endcase
      end
    end
  end

  assign hold_en = hold_r | mem_wait_i;
  assign busy_o  = (state != IDLE);

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control unit that drives the fetch-side control interface: `jump_en`/`jump_addr`/`hold_en` into `pc_regs`, and `hold_en`/`flush_en` into `if_id`.
- Arbitrates redirect requests from EX, load-use stalls from ID, multicycle-op stalls from EX, and data-memory wait.
- Converts these into registered, cycle-exact jump, hold and flush pulses.

Parameters:
- FLUSH_CYCLES, 2, number of bubble cycles `flush_en` stays high after a jump is issued (1..15).
- MC_W, 6, width of the multicycle stall length input.
- ADDR_W, 32, width of jump addresses.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- jump_req_i  input  1  redirect request from EX, single-cycle pulse.
- jump_addr_i  input  ADDR_W  redirect target, valid with `jump_req_i`.
- load_use_i  input  1  load-use hazard from ID; requests one stall cycle.
- mc_start_i  input  1  multicycle op start pulse from EX.
- mc_cycles_i  input  MC_W  stall length K for `mc_start_i`; 0 means no stall.
- mem_wait_i  input  1  data memory busy, level.
- jump_en  output  1  to `pc_regs`: load `jump_addr` this cycle.
- jump_addr  output  ADDR_W  to `pc_regs`: redirect target.
- hold_en  output  1  to `pc_regs`/`if_id`: freeze PC and IF/ID.
- flush_en  output  1  to `if_id`/ID: replace stage contents with bubble.
- busy_o  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, immediate):
  - State IDLE; all counters cleared; pending jump cleared.
  - `jump_en`, `hold_en`, `flush_en`, `busy_o` = 0; `jump_addr` = 0.
  - Reset mid-operation aborts everything, including a pending jump.
- States: IDLE, MC_STALL, FLUSH.
- `hold_en` = `hold_r` | `mem_wait_i`. The `mem_wait_i` term is combinational; all other output terms are registered.
- IDLE:
  - `jump_req_i` at cycle N → cycle N+1: `jump_en` = 1 for exactly one cycle, `jump_addr` = captured `jump_addr_i`, `flush_en` = 1.
  - Enter FLUSH with flush counter = FLUSH_CYCLES.
  - Jump has priority: `load_use_i`/`mc_start_i` in the same cycle are dropped.
  - `mc_start_i` with K ≥ 1 at N → `hold_r` = 1 for cycles N+1..N+K, then deasserts. State MC_STALL while counting.
  - `mc_start_i` with K = 0 is ignored.
  - `load_use_i` at N → `hold_r` = 1 for cycle N+1 only. State stays IDLE.
  - `mc_start_i` and `load_use_i` together → the MC stall alone (K cycles); a K = 0 start falls back to the load-use single hold.
- MC_STALL:
  - Counter decrements every cycle, independent of `mem_wait_i`.
  - At count 1 → return to IDLE; `hold_r` drops the cycle after the last stall cycle.
  - `jump_req_i` during MC_STALL is latched as pending; later requests overwrite the address.
  - The pending jump issues (`jump_en` + FLUSH) in the cycle `hold_r` first reads 0.
  - `load_use_i`/`mc_start_i` during MC_STALL are ignored.
- FLUSH:
  - `flush_en` = 1 while the counter is > 0.
  - Counter decrements only when `mem_wait_i` = 0.
  - At 0 → IDLE, `flush_en` = 0.
  - New `jump_req_i` during FLUSH → `jump_en` pulses again at the next cycle with the new address; counter reloads to FLUSH_CYCLES.
  - `load_use_i`/`mc_start_i` during FLUSH are ignored (the instruction is being flushed).
- `jump_en` is never high on two consecutive cycles unless two jump requests arrive on consecutive cycles.
- `jump_en` and `hold_r` are never both high.
- `mc_cycles_i` is MC_W bits, unsigned, no wrap: maximum stall is 2^MC_W − 1 cycles.

Test Plan:
- Reset release, no stimulus, 10 cycles → all outputs 0, `busy_o` = 0. Assert `rst` mid-FLUSH → outputs 0 in the same cycle, no stray `jump_en` after release.
- `jump_req_i` = 1, `jump_addr_i` = 0x0000_0100 at cycle 5 → `jump_en` high only at cycle 6 with `jump_addr` = 0x100; `flush_en` high cycles 6–7; `busy_o` low from cycle 8.
- `mc_start_i` with `mc_cycles_i` = 4 at cycle 3 → `hold_en` high cycles 4–7, low at 8. A `jump_req_i` to 0x200 at cycle 5 → `jump_en` at cycle 8 with 0x200, `flush_en` cycles 8–9.
- `load_use_i` at cycle 2 → `hold_en` high cycle 3 only. `load_use_i` + `mc_start_i` (K = 3) at cycle 2 → `hold_en` cycles 3–5 only.
- Jump to 0x40 at cycle 1, `mem_wait_i` high cycles 2–4 → `flush_en` stays high cycles 2–6, `hold_en` high cycles 2–4.
- Jump to 0x40 at cycle 1, jump to 0x80 at cycle 2 → `jump_en` at cycles 2 (0x40) and 3 (0x80); `flush_en` high cycles 2–4.
